// File: rtl/router_node.sv
// Three-port ring router node: cw, ccw and PE ports, two VCs per link.
// The VC equal to polarity moves through the crossbar; the other VC uses the links.
module router_node (
    input  logic        clk,
    input  logic        reset,
    output logic        polarity,
    input  logic        cwsi,
    input  logic        ccwsi,
    input  logic        pesi,
    input  logic [63:0] cwdi,
    input  logic [63:0] ccwdi,
    input  logic [63:0] pedi,
    output logic        cwri,
    output logic        ccwri,
    output logic        peri,
    output logic        cwso,
    output logic        ccwso,
    output logic        peso,
    output logic [63:0] cwdo,
    output logic [63:0] ccwdo,
    output logic [63:0] pedo,
    input  logic        cwro,
    input  logic        ccwro,
    input  logic        pero
);

    // Port index: 0 = cw, 1 = ccw, 2 = pe
    logic        si [3];
    logic [63:0] di [3];
    logic        ro [3];

    logic [63:0] ib_data [3][2];
    logic [1:0]  ib_full [3];
    logic [63:0] ob_data [3][2];
    logic [1:0]  ob_full [3];
    logic        so_q [3];
    logic [63:0] do_q [3];
    logic [2:0]  ptr;

    logic [1:0]  ib_set [3];
    logic [1:0]  ib_clr [3];
    logic [1:0]  ob_set [3];
    logic [1:0]  ob_clr [3];
    logic [63:0] ob_in  [3];

    logic [1:0]  vmask;
    logic [63:0] cw_pkt;
    logic [63:0] ccw_pkt;
    logic [63:0] pe_pkt;
    logic        cw_fwd;
    logic        cw_ej;
    logic        ccw_fwd;
    logic        ccw_ej;
    logic        pe_cw;
    logic        pe_ccw;
    logic [1:0]  g_cw;
    logic [1:0]  g_ccw;
    logic [1:0]  g_pe;

    assign si[0] = cwsi;
    assign si[1] = ccwsi;
    assign si[2] = pesi;
    assign di[0] = cwdi;
    assign di[1] = ccwdi;
    assign di[2] = pedi;
    assign ro[0] = cwro;
    assign ro[1] = ccwro;
    assign ro[2] = pero;

    assign cwri  = ~ib_full[0][!polarity];
    assign ccwri = ~ib_full[1][!polarity];
    assign peri  = ~ib_full[2][!polarity];

    assign cwso  = so_q[0];
    assign ccwso = so_q[1];
    assign peso  = so_q[2];
    assign cwdo  = do_q[0];
    assign ccwdo = do_q[1];
    assign pedo  = do_q[2];

    // Two-requester round robin; pri_b set means requester b goes first.
    function automatic logic [1:0] arb(
        input logic ra,
        input logic rb,
        input logic pri_b,
        input logic free
    );
        logic ga;
        logic gb;
        ga = free & ra & (~rb | ~pri_b);
        gb = free & rb & (~ra | pri_b);
        return {gb, ga};
    endfunction

    // Ring forwarding consumes one hop: hop vector shifts right by one.
    function automatic logic [63:0] fwd(input logic [63:0] p);
        return {p[63:56], 1'b0, p[55:49], p[47:0]};
    endfunction

    always_comb begin
        vmask   = polarity ? 2'b10 : 2'b01;
        cw_pkt  = ib_data[0][polarity];
        ccw_pkt = ib_data[1][polarity];
        pe_pkt  = ib_data[2][polarity];

        cw_fwd  = ib_full[0][polarity] &  cw_pkt[48];
        cw_ej   = ib_full[0][polarity] & ~cw_pkt[48];
        ccw_fwd = ib_full[1][polarity] &  ccw_pkt[48];
        ccw_ej  = ib_full[1][polarity] & ~ccw_pkt[48];
        pe_cw   = ib_full[2][polarity] & ~pe_pkt[62];
        pe_ccw  = ib_full[2][polarity] &  pe_pkt[62];

        g_cw  = arb(cw_fwd, pe_cw, ptr[0], ~ob_full[0][polarity]);
        g_ccw = arb(ccw_fwd, pe_ccw, ptr[1], ~ob_full[1][polarity]);
        g_pe  = arb(cw_ej, ccw_ej, ptr[2], ~ob_full[2][polarity]);

        for (int p = 0; p < 3; p++) begin
            ib_set[p] = {2{si[p]}} & ~ib_full[p]
                      & (di[p][63] ? 2'b10 : 2'b01);
            ob_clr[p] = {2{ro[p]}} & ob_full[p] & ~vmask;
        end

        ib_clr[0] = {2{g_cw[0] | g_pe[0]}} & vmask;
        ib_clr[1] = {2{g_ccw[0] | g_pe[1]}} & vmask;
        ib_clr[2] = {2{g_cw[1] | g_ccw[1]}} & vmask;

        ob_set[0] = {2{|g_cw}} & vmask;
        ob_set[1] = {2{|g_ccw}} & vmask;
        ob_set[2] = {2{|g_pe}} & vmask;

        ob_in[0] = g_cw[0]  ? fwd(cw_pkt)  : pe_pkt;
        ob_in[1] = g_ccw[0] ? fwd(ccw_pkt) : pe_pkt;
        ob_in[2] = g_pe[0]  ? cw_pkt       : ccw_pkt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            polarity <= 1'b0;
            ptr      <= 3'b000;
            for (int p = 0; p < 3; p++) begin
                ib_full[p] <= 2'b00;
                ob_full[p] <= 2'b00;
                so_q[p]    <= 1'b0;
                do_q[p]    <= 64'd0;
            end
        end else begin
            polarity <= ~polarity;
            ptr[0] <= (|g_cw)  ? g_cw[0]  : ptr[0];
            ptr[1] <= (|g_ccw) ? g_ccw[0] : ptr[1];
            ptr[2] <= (|g_pe)  ? g_pe[0]  : ptr[2];
            for (int p = 0; p < 3; p++) begin
                ib_full[p] <= (ib_full[p] | ib_set[p]) & ~ib_clr[p];
                ob_full[p] <= (ob_full[p] | ob_set[p]) & ~ob_clr[p];
                so_q[p]    <= |ob_clr[p];
                do_q[p]    <= (|ob_clr[p]) ? ob_data[p][!polarity] : 64'd0;
            end
        end
    end

    // Payload storage needs no reset; validity lives in the full flags.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            for (int v = 0; v < 2; v++) begin
                if (ib_set[p][v])
                    ib_data[p][v] <= di[p];
                if (ob_set[p][v])
                    ob_data[p][v] <= ob_in[p];
            end
        end
    end

endmodule

// File: tb/tb_router_node.sv
// Directed bench for router_node with a scoreboard of expected
// (output port, packet) pairs matched as packets leave the node.
module tb_router_node;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        cwsi, ccwsi, pesi;
    logic [63:0] cwdi, ccwdi, pedi;
    logic        cwri, ccwri, peri;
    logic        cwso, ccwso, peso;
    logic [63:0] cwdo, ccwdo, pedo;
    logic        cwro, ccwro, pero;

    typedef struct {
        int          port;
        logic [63:0] data;
    } exp_t;

    exp_t     exp_q[$];
    logic [3:0] cw_log[$];
    int       checks = 0;
    int       failures = 0;
    logic     prev_pol = 1'b0;
    logic     logging = 1'b0;

    always #5 clk = ~clk;

    router_node dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
        .cwdi(cwdi), .ccwdi(ccwdi), .pedi(pedi),
        .cwri(cwri), .ccwri(ccwri), .peri(peri),
        .cwso(cwso), .ccwso(ccwso), .peso(peso),
        .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo),
        .cwro(cwro), .ccwro(ccwro), .pero(pero)
    );

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            failures++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
        end \
    end

    task automatic check_out(input int port, input logic [63:0] d);
        int idx = -1;
        foreach (exp_q[i])
            if (idx < 0 && exp_q[i].port == port && exp_q[i].data === d)
                idx = i;
        checks++;
        assert (idx >= 0) else begin
            failures++;
            $error("FAIL out_port%0d observed=%h expected=pending_entry", port, d);
        end
        if (idx >= 0)
            exp_q.delete(idx);
    endtask

    task automatic check_vc(input int port, input logic [63:0] d);
        checks++;
        assert (d[63] !== prev_pol) else begin
            failures++;
            $error("FAIL vc_phase_port%0d observed=%0b expected=%0b", port, d[63], ~prev_pol);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (cwso) begin
                check_out(0, cwdo);
                check_vc(0, cwdo);
                if (logging)
                    cw_log.push_back(cwdo[31:28]);
            end
            if (ccwso) begin
                check_out(1, ccwdo);
                check_vc(1, ccwdo);
            end
            if (peso) begin
                check_out(2, pedo);
                check_vc(2, pedo);
            end
        end
        prev_pol = polarity;
    end

    function automatic logic ri_of(input int port);
        case (port)
            0: return cwri;
            1: return ccwri;
            default: return peri;
        endcase
    endfunction

    task automatic drive(input int port, input logic s, input logic [63:0] d);
        case (port)
            0: begin cwsi = s; cwdi = d; end
            1: begin ccwsi = s; ccwdi = d; end
            default: begin pesi = s; pedi = d; end
        endcase
    endtask

    // Called at a negedge: waits for ready, sends on the VC ready refers to.
    task automatic inj(input int port, input logic [62:0] body,
                       input int oport, input logic [62:0] ebody);
        int   n = 0;
        logic vc;
        while (ri_of(port) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            failures++;
            $error("FAIL inj_ready_wait observed=%0d expected=<50", n);
        end
        vc = ~polarity;
        drive(port, 1'b1, {vc, body});
        exp_q.push_back('{oport, {vc, ebody}});
        @(negedge clk);
        drive(port, 1'b0, 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        `CHK("drain_pending", exp_q.size(), 0)
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic p0;
        logic vc;
        int   ncw;
        int   npe;
        logic saw_stall;
        logic has_c;
        logic has_e;

        reset = 1'b1;
        cwsi = 0; ccwsi = 0; pesi = 0;
        cwdi = '0; ccwdi = '0; pedi = '0;
        cwro = 1; ccwro = 1; pero = 1;

        repeat (3) @(negedge clk);
        `CHK("rst_polarity", polarity, 1'b0)
        `CHK("rst_so", {cwso, ccwso, peso}, 3'b000)
        `CHK("rst_do", {cwdo, ccwdo, pedo}, 192'd0)
        `CHK("rst_ri", {cwri, ccwri, peri}, 3'b111)

        reset = 1'b0;
        @(negedge clk);
        p0 = polarity;
        `CHK("pol_first", p0, 1'b1)
        @(negedge clk);
        `CHK("pol_toggle1", polarity, ~p0)
        @(negedge clk);
        `CHK("pol_toggle2", polarity, p0)

        // cw forward: hop 0F becomes 07
        inj(0, {1'b0, 6'b0, 8'h0F, 16'h0, 32'hDEADBEEF},
            0, {1'b0, 6'b0, 8'h07, 16'h0, 32'hDEADBEEF});
        drain();

        // ccw ejection: hop bit0 clear, packet unchanged
        inj(1, {1'b1, 6'b0, 8'h02, 16'h1234, 32'hCAFEF00D},
            2, {1'b1, 6'b0, 8'h02, 16'h1234, 32'hCAFEF00D});
        drain();

        // PE injection toward ccw, hop untouched
        inj(2, {1'b1, 6'b0, 8'hFF, 16'hABCD, 32'h00C0FFEE},
            1, {1'b1, 6'b0, 8'hFF, 16'hABCD, 32'h00C0FFEE});
        drain();

        // PE injection toward cw
        inj(2, {1'b0, 6'b0, 8'h55, 16'h0001, 32'h11112222},
            0, {1'b0, 6'b0, 8'h55, 16'h0001, 32'h11112222});
        drain();

        // Back-pressure: PE output blocked, cw inputs fill on both VCs
        pero = 0;
        for (int i = 0; i < 4; i++)
            inj(0, {1'b0, 6'b0, 8'h00, 16'h0, 32'hB0000000 | 32'(i)},
                2, {1'b0, 6'b0, 8'h00, 16'h0, 32'hB0000000 | 32'(i)});
        repeat (4) @(negedge clk);
        `CHK("bp_cwri_phase_a", cwri, 1'b0)
        @(negedge clk);
        `CHK("bp_cwri_phase_b", cwri, 1'b0)
        `CHK("bp_held", exp_q.size(), 4)
        pero = 1;
        drain();

        // Contention for cw output between cw input and PE input
        ncw = 0;
        npe = 0;
        saw_stall = 0;
        cw_log.delete();
        logging = 1;
        for (int c = 0; c < 200 && (ncw < 8 || npe < 8); c++) begin
            cwsi = 0;
            pesi = 0;
            if (!cwri || !peri)
                saw_stall = 1;
            vc = ~polarity;
            if (cwri && ncw < 8) begin
                cwsi = 1;
                cwdi = {vc, 1'b0, 6'b0, 8'h0F, 16'h0, 32'hC0000000 | 32'(ncw)};
                exp_q.push_back('{0, {vc, 1'b0, 6'b0, 8'h07, 16'h0,
                                      32'hC0000000 | 32'(ncw)}});
                ncw++;
            end
            if (peri && npe < 8) begin
                pesi = 1;
                pedi = {vc, 1'b0, 6'b0, 8'h33, 16'h0, 32'hE0000000 | 32'(npe)};
                exp_q.push_back('{0, {vc, 1'b0, 6'b0, 8'h33, 16'h0,
                                      32'hE0000000 | 32'(npe)}});
                npe++;
            end
            @(negedge clk);
        end
        cwsi = 0;
        pesi = 0;
        `CHK("cont_cw_sent", ncw, 8)
        `CHK("cont_pe_sent", npe, 8)
        drain();
        logging = 0;
        `CHK("cont_stall_seen", saw_stall, 1'b1)
        `CHK("cont_delivered", cw_log.size(), 16)
        has_c = 0;
        has_e = 0;
        for (int i = 0; i < 4 && i < cw_log.size(); i++) begin
            if (cw_log[i] == 4'hC) has_c = 1;
            if (cw_log[i] == 4'hE) has_e = 1;
        end
        `CHK("cont_rr_fair", {has_c, has_e}, 2'b11)
        if (cw_log.size() >= 2) begin
            `CHK("cont_first_ring", cw_log[0], 4'hC)
            `CHK("cont_second_pe", cw_log[1], 4'hE)
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
